// File: rtl/atm_keypad_entry.sv
// atm_keypad_entry: keypad front-end for the ATM controller.
// Collects digit keys into a BCD buffer, handles clear/cancel/enter and an
// inactivity timeout, then converts the buffer to binary one digit per cycle
// and holds the result on a valid/ready output.
// Optional feature macro: KEYPAD_BACKSPACE_EN (key B removes the last digit).
module atm_keypad_entry #(
    parameter int unsigned PIN_DIGITS     = 4,
    parameter int unsigned AMT_DIGITS     = 5,
    parameter int unsigned TIMEOUT_CYCLES = 1000   // must be >= 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        mode,
    input  logic        key_valid,
    input  logic [3:0]  key_code,
    output logic        key_ready,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [18:0] out_value,
    output logic [2:0]  out_digits,
    output logic        entry_error,
    output logic        cancelled,
    output logic        timeout,
    output logic        busy
);

    localparam int unsigned MAX_DIGITS = (PIN_DIGITS > AMT_DIGITS) ? PIN_DIGITS : AMT_DIGITS;
    localparam int unsigned BUF_W      = 4 * MAX_DIGITS;
    localparam int unsigned TMR_W      = $clog2(TIMEOUT_CYCLES) + 1;

    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
    localparam logic [2:0]       PIN_CNT  = 3'(PIN_DIGITS);
    localparam logic [2:0]       AMT_CNT  = 3'(AMT_DIGITS);
    localparam logic [7:0]       BUF_BITS = 8'(BUF_W);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ENTRY   = 2'd1;
    localparam logic [1:0] ST_CONVERT = 2'd2;
    localparam logic [1:0] ST_HOLD    = 2'd3;

    localparam logic [3:0] KEY_CLEAR  = 4'hA;
    localparam logic [3:0] KEY_BACK   = 4'hB;
    localparam logic [3:0] KEY_ENTER  = 4'hC;
    localparam logic [3:0] KEY_CANCEL = 4'hD;

    logic [1:0]       state_q, state_d;
    logic             mode_q, mode_d;
    logic [BUF_W-1:0] buf_q, buf_d;
    logic [2:0]       cnt_q, cnt_d;
    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic [BUF_W-1:0] conv_q, conv_d;
    logic [2:0]       rem_q, rem_d;
    logic [18:0]      acc_q, acc_d;
    logic             err_q, err_d;
    logic             can_q, can_d;
    logic             tmo_q, tmo_d;

    logic [2:0]       max_cnt;
    logic             enter_ok;
    logic [7:0]       shamt;
    logic [TMR_W-1:0] tmr_inc;
    logic [3:0]       conv_digit;

    assign max_cnt    = mode_q ? AMT_CNT : PIN_CNT;
    assign enter_ok   = mode_q ? (cnt_q != 3'd0) : (cnt_q == PIN_CNT);
    // Left-align the entered digits so the most significant one sits in the top nibble.
    assign shamt      = BUF_BITS - {3'b000, cnt_q, 2'b00};
    assign tmr_inc    = tmr_q + TMR_W'(1);
    assign conv_digit = conv_q[BUF_W-1 -: 4];

    // Next-state logic for the session FSM, buffer, timer and converter.
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        buf_d   = buf_q;
        cnt_d   = cnt_q;
        tmr_d   = tmr_q;
        conv_d  = conv_q;
        rem_d   = rem_q;
        acc_d   = acc_q;
        err_d   = 1'b0;
        can_d   = 1'b0;
        tmo_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    mode_d  = mode;
                    buf_d   = '0;
                    cnt_d   = '0;
                    tmr_d   = '0;
                    acc_d   = '0;
                    state_d = ST_ENTRY;
                end
            end

            ST_ENTRY: begin
                // A consumed key always wins over the timeout on the same edge.
                if (key_valid) begin
                    tmr_d = '0;
                    if (key_code <= 4'd9) begin
                        if (cnt_q < max_cnt) begin
                            buf_d = {buf_q[BUF_W-5:0], key_code};
                            cnt_d = cnt_q + 3'd1;
                        end
                    end else begin
                        case (key_code)
                            KEY_CLEAR: begin
                                buf_d = '0;
                                cnt_d = '0;
                            end
                            KEY_BACK: begin
`ifdef KEYPAD_BACKSPACE_EN
                                if (cnt_q != 3'd0) begin
                                    buf_d = buf_q >> 4;
                                    cnt_d = cnt_q - 3'd1;
                                end
`endif
                            end
                            KEY_ENTER: begin
                                if (enter_ok) begin
                                    conv_d  = buf_q << shamt;
                                    rem_d   = cnt_q;
                                    acc_d   = '0;
                                    state_d = ST_CONVERT;
                                end else begin
                                    err_d = 1'b1;
                                end
                            end
                            KEY_CANCEL: begin
                                can_d   = 1'b1;
                                buf_d   = '0;
                                cnt_d   = '0;
                                state_d = ST_IDLE;
                            end
                            default: ;
                        endcase
                    end
                end else if (tmr_inc == TMR_LAST) begin
                    tmo_d   = 1'b1;
                    buf_d   = '0;
                    cnt_d   = '0;
                    tmr_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    tmr_d = tmr_inc;
                end
            end

            ST_CONVERT: begin
                acc_d  = (acc_q << 3) + (acc_q << 1) + 19'(conv_digit);
                conv_d = conv_q << 4;
                rem_d  = rem_q - 3'd1;
                if (rem_q == 3'd1) begin
                    state_d = ST_HOLD;
                end
            end

            ST_HOLD: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            mode_q  <= 1'b0;
            buf_q   <= '0;
            cnt_q   <= '0;
            tmr_q   <= '0;
            conv_q  <= '0;
            rem_q   <= '0;
            acc_q   <= '0;
            err_q   <= 1'b0;
            can_q   <= 1'b0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            buf_q   <= buf_d;
            cnt_q   <= cnt_d;
            tmr_q   <= tmr_d;
            conv_q  <= conv_d;
            rem_q   <= rem_d;
            acc_q   <= acc_d;
            err_q   <= err_d;
            can_q   <= can_d;
            tmo_q   <= tmo_d;
        end
    end

    assign key_ready   = (state_q == ST_ENTRY);
    assign out_valid   = (state_q == ST_HOLD);
    assign busy        = (state_q != ST_IDLE);
    assign out_value   = acc_q;
    assign out_digits  = cnt_q;
    assign entry_error = err_q;
    assign cancelled   = can_q;
    assign timeout     = tmo_q;

endmodule
